// File: rtl/regfile_wb_if.sv
// Write-back request channels shared by the two requesters and the arbiter.
// Each requester drives valid/addr/data; the arbiter returns ready.
interface regfile_wb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            req0_valid;
  logic [AW-1:0]   req0_addr;
  logic [XLEN-1:0] req0_data;
  logic            req0_ready;
  logic            req1_valid;
  logic [AW-1:0]   req1_addr;
  logic [XLEN-1:0] req1_data;
  logic            req1_ready;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port owner: clears x1..x(NREG-1) after reset, then
// arbitrates two write-back requesters round-robin onto a registered port.
module regfile_wb_arbiter #(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_wb_if.slave             req,
  output logic                    we3,
  output logic [$clog2(NREG)-1:0] a3,
  output logic [XLEN-1:0]         wd3,
  output logic                    init_done
);
  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state, next_state;
  logic [AW-1:0] cnt;
  logic          rr;    // 0: req0 wins a tie, 1: req1 wins a tie
  logic          gnt0, gnt1;
  logic          both_valid;

  assign both_valid = req.req0_valid && req.req1_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else        state <= next_state;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      CLEAR:   if (cnt == LAST_REG) next_state = RUN;
      RUN:     next_state = RUN;
      default: next_state = CLEAR;
    endcase
  end

  // Grants never look at ready, so valid->ready is the only comb path.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == RUN) begin
      gnt0 = req.req0_valid && (!req.req1_valid || !rr);
      gnt1 = req.req1_valid && (!req.req0_valid ||  rr);
    end
  end

  assign req.req0_ready = gnt0;
  assign req.req1_ready = gnt1;
  assign init_done      = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= AW'(1);
      rr  <= 1'b0;
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else if (state == CLEAR) begin
      we3 <= 1'b1;
      a3  <= cnt;
      wd3 <= '0;
      cnt <= cnt + AW'(1);
    end else begin
      if (gnt0) begin
        we3 <= |req.req0_addr;
        a3  <= req.req0_addr;
        wd3 <= req.req0_data;
      end else if (gnt1) begin
        we3 <= |req.req1_addr;
        a3  <= req.req1_addr;
        wd3 <= req.req1_data;
      end else begin
        we3 <= 1'b0;
      end
      if (both_valid) rr <= ~rr;
    end
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and initialisation sequencer for the 32×32 register file write port (`we3`/`a3`/`wd3`). After reset it zeroes registers x1–x31, one per cycle, because the register array itself has no reset. It then shares the single write port between two write-back requesters (req0: ALU/immediate path, req1: load/CSR path) using valid/ready handshakes and round-robin priority. Its outputs are registered and drive the register file write port directly.

## Interface
- `NREG`, 32, number of architectural registers; x0 is never written.
- `XLEN`, 32, data width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has a write pending.
- `req0_addr`  in  5  destination register of requester 0.
- `req0_data`  in  XLEN  write data of requester 0.
- `req0_ready`  out  1  requester 0 write accepted this cycle.
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `we3`  out  1  register file write enable (registered).
- `a3`  out  5  register file write address (registered).
- `wd3`  out  XLEN  register file write data (registered).
- `init_done`  out  1  high once the clear sequence has completed; stays high until the next reset.

## Operation
- States: CLEAR, RUN. Reset state is CLEAR, with clear counter `cnt` = 1 and round-robin pointer `rr` = 0 (req0 preferred).
- CLEAR state:
  - Each cycle registers `we3`=1, `a3`=`cnt`, `wd3`=0, then increments `cnt`.
  - When `cnt` = NREG−1 is issued, the next state is RUN and `init_done` is set on the same edge.
  - `req0_ready` = `req1_ready` = 0 throughout.
- RUN state, grant logic (combinational `readyN`):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester selected by `rr` is granted, and `rr` flips to the other requester on that edge.
  - `rr` flips only when both requesters were valid.
  - Neither valid: no grant.
- Handshake:
  - A transfer occurs on a rising edge where `reqN_valid`=1 and `reqN_ready`=1.
  - A requester holds valid, addr and data stable until the transfer.
  - `ready` may not be used to decide `valid`, so there is no combinational loop.
  - A denied requester keeps `ready`=0 and waits; with both requesters valid continuously, the grants strictly alternate.
- Output register:
  - On a transfer, next-cycle `we3` = (addr ≠ 0), `a3` = addr, `wd3` = data.
  - A write to x0 is accepted (ready=1) and consumes the slot, but `we3`=0.
  - With no transfer: `we3`=0, and `a3`/`wd3` hold their previous values.
- Both requesters targeting the same register: the writes are serialized in grant order; the later-granted value persists.
- Reset asserted at any time, including mid-clear or with a write pending on the output register:
  - Forces `we3`=0 immediately and drops the pending write.
  - Returns to CLEAR; the full clear sequence restarts on release.

## Timing
- Reset values: `we3`=0, `a3`=0, `wd3`=0, `init_done`=0, `req0_ready`=`req1_ready`=0.
- Clear sequence:
  - Edge E1 is the first rising edge with `rst_n` high.
  - From E1, `we3` is high for exactly NREG−1 (31) consecutive cycles, with `a3` = 1, 2, …, 31.
  - `init_done` rises at edge E31; ready can first assert in the cycle after E31.
- Write latency:
  - A transfer at edge k gives `we3`/`a3`/`wd3` valid during cycle k..k+1.
  - The register file commits the write at edge k+1, and it is readable combinationally after k+1.
- Throughput: one write per cycle in RUN; the port is never idle while any request is pending.

## Test plan
- Reset release, no requests -> `we3` high for 31 cycles with `a3`=1..31 and `wd3`=0; `init_done` goes 0→1 after the 31st write; afterwards every register reads 0.
- RUN, req0 alone writes x5=0xDEADBEEF -> `req0_ready`=1 in the same cycle; next cycle `we3`=1, `a3`=5, `wd3`=0xDEADBEEF; x5 reads 0xDEADBEEF after the following edge.
- Both requesters held valid for 6 cycles (req0→x1=0x11, req1→x2=0x22) -> grants alternate req0, req1, req0, …; neither requester waits more than 1 cycle.
- Both write x7 simultaneously (req0=0xAAAA, req1=0xBBBB) with `rr`=0 -> req0 is granted first, then req1; x7 ends at 0xBBBB.
- req1 writes x0=0x1234 -> `req1_ready`=1; next cycle `we3`=0; x0 still reads 0; the next write from req0 is granted in the following cycle.
- `rst_n` pulsed low at clear write `a3`=12, with a RUN write pending -> `we3` drops to 0 asynchronously and `init_done`=0; after release the clear sequence restarts from `a3`=1 and no stale write appears.
